// File: rtl/bldc_pi_sequencer.sv
// PI speed-loop sequencer: one update per control tick, sharing an external
// pipelined signed multiplier between the P and I terms, with integrator anti-windup.
module bldc_pi_sequencer #(
    parameter int DW      = 16,
    parameter int KW      = 16,
    parameter int FRAC    = 8,
    parameter int MUL_LAT = 3,
    parameter int OUT_MIN = 0,
    parameter int OUT_MAX = 1000
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  enable,
    input  logic                  tick,
    input  logic signed [DW-1:0]  setpoint,
    input  logic signed [DW-1:0]  feedback,
    input  logic [KW-1:0]         kp,
    input  logic [KW-1:0]         ki,
    output logic signed [DW:0]    mul_a,
    output logic [KW-1:0]         mul_b,
    output logic                  mul_valid,
    input  logic signed [DW+KW:0] mul_p,
    input  logic                  mul_p_valid,
    output logic signed [DW-1:0]  duty,
    output logic                  duty_valid,
    output logic                  busy,
    output logic                  sat_flag,
    output logic                  overrun,
    output logic                  mul_err
);
    localparam int PW = DW + KW + 1;
    localparam int AW = DW + KW + 2;
    localparam int TW = 8;
    localparam logic signed [AW-1:0] MIN_W = AW'(OUT_MIN);
    localparam logic signed [AW-1:0] MAX_W = AW'(OUT_MAX);
    localparam logic [TW-1:0] TMO_LAST = TW'(MUL_LAT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE_P, ISSUE_I, WAIT, SUM, OUT} state_t;
    state_t state_reg, state_next;

    logic signed [DW:0]    err_reg, err_next;
    logic [KW-1:0]         kp_reg, ki_reg;
    logic signed [PW-1:0]  prod_p_reg, prod_i_reg;
    logic                  have_p_reg, have_i_reg;
    logic [TW-1:0]         timer_reg;
    logic signed [AW-1:0]  integ_reg, integ_next;
    logic signed [AW-1:0]  u_reg, u_next;
    logic signed [AW-1:0]  p_term, i_term, duty_w;
    logic signed [DW-1:0]  duty_reg;
    logic                  duty_valid_reg, sat_reg, overrun_reg, mul_err_reg;
    logic                  capture_en, prod_done, timeout;

    function automatic logic signed [AW-1:0] clamp(input logic signed [AW-1:0] x);
        if (x < MIN_W)
            return MIN_W;
        else if (x > MAX_W)
            return MAX_W;
        return x;
    endfunction

    assign err_next   = (DW+1)'(setpoint) - (DW+1)'(feedback);
    assign capture_en = (state_reg == ISSUE_I) || (state_reg == WAIT);
    // Done once the second product is held, counting one arriving this cycle.
    assign prod_done  = have_i_reg || (have_p_reg && mul_p_valid && capture_en);
    assign timeout    = (state_reg == WAIT) && !prod_done && (timer_reg == TMO_LAST);

    always_comb begin
        p_term     = AW'(prod_p_reg) >>> FRAC;
        i_term     = AW'(prod_i_reg) >>> FRAC;
        integ_next = clamp(integ_reg + i_term);
        u_next     = p_term + integ_next;
        duty_w     = clamp(u_reg);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (tick) state_next = ISSUE_P;
                ISSUE_P: state_next = ISSUE_I;
                ISSUE_I: state_next = WAIT;
                WAIT: begin
                    if (prod_done)
                        state_next = SUM;
                    else if (timeout)
                        state_next = IDLE;
                end
                SUM:     state_next = OUT;
                OUT:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        mul_a     = '0;
        mul_b     = '0;
        mul_valid = 1'b0;
        if (state_reg == ISSUE_P) begin
            mul_a     = err_reg;
            mul_b     = kp_reg;
            mul_valid = 1'b1;
        end else if (state_reg == ISSUE_I) begin
            mul_a     = err_reg;
            mul_b     = ki_reg;
            mul_valid = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            err_reg        <= '0;
            kp_reg         <= '0;
            ki_reg         <= '0;
            prod_p_reg     <= '0;
            prod_i_reg     <= '0;
            have_p_reg     <= 1'b0;
            have_i_reg     <= 1'b0;
            timer_reg      <= '0;
            integ_reg      <= '0;
            u_reg          <= '0;
            duty_reg       <= '0;
            duty_valid_reg <= 1'b0;
            sat_reg        <= 1'b0;
            overrun_reg    <= 1'b0;
            mul_err_reg    <= 1'b0;
        end else begin
            duty_valid_reg <= 1'b0;
            overrun_reg    <= tick && (state_reg != IDLE);
            if (!enable) begin
                integ_reg   <= '0;
                duty_reg    <= '0;
                sat_reg     <= 1'b0;
                mul_err_reg <= 1'b0;
                have_p_reg  <= 1'b0;
                have_i_reg  <= 1'b0;
            end else begin
                // Products are accepted only while an update is waiting for them.
                if (capture_en && mul_p_valid) begin
                    if (!have_p_reg) begin
                        prod_p_reg <= mul_p;
                        have_p_reg <= 1'b1;
                    end else if (!have_i_reg) begin
                        prod_i_reg <= mul_p;
                        have_i_reg <= 1'b1;
                    end
                end
                case (state_reg)
                    IDLE: begin
                        if (tick) begin
                            err_reg    <= err_next;
                            kp_reg     <= kp;
                            ki_reg     <= ki;
                            have_p_reg <= 1'b0;
                            have_i_reg <= 1'b0;
                        end
                    end
                    ISSUE_I: timer_reg <= '0;
                    WAIT: begin
                        timer_reg <= timer_reg + 1'b1;
                        if (timeout)
                            mul_err_reg <= 1'b1;
                    end
                    SUM: begin
                        integ_reg <= integ_next;
                        u_reg     <= u_next;
                    end
                    OUT: begin
                        duty_reg       <= duty_w[DW-1:0];
                        sat_reg        <= (u_reg < MIN_W) || (u_reg > MAX_W);
                        duty_valid_reg <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign duty       = duty_reg;
    assign duty_valid = duty_valid_reg;
    assign busy       = (state_reg != IDLE);
    assign sat_flag   = sat_reg;
    assign overrun    = overrun_reg;
    assign mul_err    = mul_err_reg;

endmodule

// File: tb/tb_bldc_pi_sequencer.sv
// Bench for bldc_pi_sequencer: fixed-latency multiplier model, duty scoreboard,
// directed steps for gains, saturation, anti-windup, overrun, timeout and reset.
module tb_bldc_pi_sequencer;
    localparam int DW = 16, KW = 16, FRAC = 8, MUL_LAT = 3;
    localparam int OUT_MIN = 0, OUT_MAX = 1000;
    localparam int PW = DW + KW + 1;
    localparam int LAT = MUL_LAT + 4;

    logic                  ACLK, ARESETN, enable, tick;
    logic signed [DW-1:0]  setpoint, feedback;
    logic [KW-1:0]         kp, ki;
    logic signed [DW:0]    mul_a;
    logic [KW-1:0]         mul_b;
    logic                  mul_valid;
    logic signed [PW-1:0]  mul_p;
    logic                  mul_p_valid;
    logic signed [DW-1:0]  duty;
    logic                  duty_valid, busy, sat_flag, overrun, mul_err;

    bldc_pi_sequencer #(
        .DW(DW), .KW(KW), .FRAC(FRAC), .MUL_LAT(MUL_LAT),
        .OUT_MIN(OUT_MIN), .OUT_MAX(OUT_MAX)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .tick(tick),
        .setpoint(setpoint), .feedback(feedback), .kp(kp), .ki(ki),
        .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid),
        .mul_p(mul_p), .mul_p_valid(mul_p_valid),
        .duty(duty), .duty_valid(duty_valid), .busy(busy),
        .sat_flag(sat_flag), .overrun(overrun), .mul_err(mul_err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    longint cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    // Multiplier model: product presented MUL_LAT cycles after the issue cycle.
    logic signed [PW-1:0] prod_calc;
    logic signed [PW-1:0] pipe_p [MUL_LAT];
    logic                 pipe_v [MUL_LAT];
    logic                 issue_odd;
    logic                 drop_i = 1'b0;

    always_comb prod_calc = PW'(mul_a) * PW'($signed({1'b0, mul_b}));

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_p[i] <= '0;
            end
            issue_odd <= 1'b0;
        end else begin
            pipe_v[0] <= mul_valid && !(drop_i && issue_odd);
            pipe_p[0] <= prod_calc;
            for (int i = 1; i < MUL_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_p[i] <= pipe_p[i-1];
            end
            if (mul_valid)
                issue_odd <= ~issue_odd;
        end
    end
    assign mul_p_valid = pipe_v[MUL_LAT-1];
    assign mul_p       = pipe_p[MUL_LAT-1];

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    typedef struct {
        logic signed [DW-1:0] duty;
        logic                 sat;
        longint               due;
    } exp_t;
    exp_t   sb[$];
    int     dv_count = 0;
    longint integ_m = 0;
    logic signed [DW-1:0] last_duty = '0;

    always @(negedge ACLK) begin
        if (ARESETN && duty_valid) begin
            dv_count++;
            if (sb.size() == 0) begin
                check("unexpected_duty_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("duty", duty, e.duty);
                check("sat_flag", sat_flag, e.sat);
                check("latency", cyc, e.due);
            end
        end
    end

    function automatic longint clampl(input longint x);
        if (x < OUT_MIN) return OUT_MIN;
        if (x > OUT_MAX) return OUT_MAX;
        return x;
    endfunction

    // Drive operands and push the expected result for a tick on the next edge.
    task automatic push_exp(input int sp, input int fb, input int kpv, input int kiv);
        exp_t   e;
        longint err, p, iv, u;
        setpoint = DW'(sp);
        feedback = DW'(fb);
        kp       = KW'(kpv);
        ki       = KW'(kiv);
        err      = sp - fb;
        p        = (err * kpv) >>> FRAC;
        iv       = (err * kiv) >>> FRAC;
        integ_m  = clampl(integ_m + iv);
        u        = p + integ_m;
        e.duty   = DW'(clampl(u));
        e.sat    = (u < OUT_MIN) || (u > OUT_MAX);
        e.due    = cyc + 1 + LAT;
        last_duty = e.duty;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 30 && sb.size() != 0; n++) @(posedge ACLK);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(posedge ACLK);
        #1;
        tick = 1'b0;
    endtask

    task automatic do_update(input int sp, input int fb, input int kpv, input int kiv);
        push_exp(sp, fb, kpv, kiv);
        pulse_tick();
        wait_drain();
    endtask

    task automatic en_pulse();
        enable = 1'b0;
        @(posedge ACLK);
        #1;
        enable   = 1'b1;
        integ_m  = 0;
        last_duty = '0;
        check("en_low_duty", duty, 64'd0);
        check("en_low_sat", sat_flag, 64'd0);
        check("en_low_mul_err", mul_err, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dv0;
        ARESETN  = 1'b0;
        enable   = 1'b0;
        tick     = 1'b0;
        setpoint = '0;
        feedback = '0;
        kp       = '0;
        ki       = '0;
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_duty", duty, 64'd0);
        check("rst_duty_valid", duty_valid, 64'd0);
        check("rst_busy", busy, 64'd0);
        check("rst_mul_valid", mul_valid, 64'd0);
        check("rst_mul_err", mul_err, 64'd0);
        check("rst_overrun", overrun, 64'd0);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;

        // Proportional only, with operand issue checks; tick and enable rise together.
        enable = 1'b1;
        push_exp(500, 200, 256, 0);
        pulse_tick();
        check("issue_p_valid", mul_valid, 64'd1);
        check("issue_p_a", mul_a, 64'd300);
        check("issue_p_b", mul_b, 64'd256);
        check("busy", busy, 64'd1);
        setpoint = DW'(-5);
        kp       = KW'(7);
        @(posedge ACLK);
        #1;
        check("issue_i_valid", mul_valid, 64'd1);
        check("issue_i_a", mul_a, 64'd300);
        check("issue_i_b", mul_b, 64'd0);
        @(posedge ACLK);
        #1;
        check("wait_mul_valid", mul_valid, 64'd0);
        wait_drain();

        // Integral accumulation, then cleared by enable low.
        for (int k = 0; k < 3; k++) do_update(100, 0, 0, 128);
        en_pulse();
        do_update(100, 0, 0, 128);

        // Output saturation high and low.
        en_pulse();
        do_update(1000, 0, 1024, 0);
        do_update(0, 300, 256, 0);

        // Integrator clamp and recovery without windup.
        en_pulse();
        for (int k = 0; k < 5; k++) do_update(400, 0, 0, 256);
        do_update(0, 100, 0, 256);

        // Overrun: second tick three cycles into the update.
        en_pulse();
        push_exp(500, 200, 256, 0);
        pulse_tick();
        dv0 = dv_count;
        @(posedge ACLK);
        @(posedge ACLK);
        #1;
        tick = 1'b1;
        @(posedge ACLK);
        #1;
        tick = 1'b0;
        check("overrun_pulse", overrun, 64'd1);
        @(posedge ACLK);
        #1;
        check("overrun_clear", overrun, 64'd0);
        wait_drain();
        repeat (4) @(posedge ACLK);
        #1;
        check("overrun_one_duty_valid", 64'(dv_count - dv0), 64'd1);

        // Withheld integral product: timeout sets mul_err.
        drop_i   = 1'b1;
        setpoint = DW'(900);
        feedback = DW'(0);
        pulse_tick();
        dv0 = dv_count;
        for (int k = 1; k <= MUL_LAT + 4; k++) begin
            @(posedge ACLK);
            #1;
            check($sformatf("mul_err_c%0d", k), mul_err, 64'(k == MUL_LAT + 4));
        end
        check("timeout_idle", busy, 64'd0);
        check("timeout_duty_held", duty, last_duty);
        drop_i = 1'b0;
        repeat (4) @(posedge ACLK);
        #1;
        check("timeout_no_duty_valid", 64'(dv_count - dv0), 64'd0);
        check("mul_err_sticky", mul_err, 64'd1);

        // Asynchronous reset in the middle of WAIT.
        pulse_tick();
        @(posedge ACLK);
        @(posedge ACLK);
        #1;
        check("pre_reset_busy", busy, 64'd1);
        #2;
        ARESETN = 1'b0;
        #1;
        check("arst_duty", duty, 64'd0);
        check("arst_busy", busy, 64'd0);
        check("arst_mul_err", mul_err, 64'd0);
        check("arst_mul_valid", mul_valid, 64'd0);
        check("arst_duty_valid", duty_valid, 64'd0);
        check("arst_sat", sat_flag, 64'd0);
        @(posedge ACLK);
        #1;
        ARESETN  = 1'b1;
        integ_m  = 0;
        @(posedge ACLK);
        #1;
        do_update(500, 200, 256, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
